bsr_load_ctrl: RTL and testbench
================================

Name: bsr_load_ctrl

Overview:
Sequencer for the team's bidirectional shift register (BSR). It accepts a parallel word over a valid/ready handshake and streams it serially into the BSR, driving the BSR's d/dir/en pins for exactly WIDTH cycles. It then reads back the BSR's parallel output and reports completion with a mismatch flag. It sits between a host/config interface and a BSR instance of matching width.

Parameters:
WIDTH, 4, width of the BSR and of the request word (>=2)
CNT_W, 3, bit counter width; must satisfy 2**CNT_W > WIDTH

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous reset, active-high
req_valid  input  1  request present
req_ready  output  1  controller can accept a request
req_data  input  WIDTH  word to load into BSR
req_dir  input  1  shift direction to use (0 = right, 1 = left)
abort  input  1  synchronous cancel of an in-flight load
sr_d  output  1  serial data to BSR d
sr_dir  output  1  to BSR dir
sr_en  output  1  to BSR en
sr_out  input  WIDTH  BSR parallel output
done  output  1  one-cycle completion pulse
result_data  output  WIDTH  BSR contents captured at completion
mismatch  output  1  result_data != loaded word; valid while done=1

Behaviour:
- BSR contract: on a rising edge with en=1, dir=0 shifts right (d enters bit WIDTH-1); dir=1 shifts left (d enters bit 0). en=0 holds.
- States: IDLE, SHIFT, CHECK, DONE. State encoding is 2-bit binary.
- Reset (async, rst=1): state=IDLE, counter=0, sr_d=0, sr_dir=0, sr_en=0, done=0, mismatch=0, result_data=0, and internal data/dir registers=0.
- IDLE: req_ready=1. When req_valid=1 on an edge, capture req_data and req_dir, clear the counter, and go to SHIFT. abort is ignored in IDLE.
- SHIFT: lasts exactly WIDTH cycles (counter k = 0..WIDTH-1).
  - sr_en=1 and sr_dir=captured dir.
  - sr_d = data[k] when dir=0 (LSB first); sr_d = data[WIDTH-1-k] when dir=1 (MSB first).
  - After the edge at k=WIDTH-1, go to CHECK.
- CHECK: one cycle with sr_en=0. At its closing edge, result_data<=sr_out and mismatch<=(sr_out!=data); go to DONE.
- DONE: one cycle with done=1 and sr_en=0. result_data holds its value until the next CHECK. Return to IDLE.
- sr_d/sr_dir/sr_en are decoded from state, counter and captured registers only (Moore). They are driven from flops or flop-only decode, with no combinational path from request inputs.
- req_ready=1 only in IDLE. It is 0 in all other states, including the DONE cycle.
- Latency: accept edge at cycle 0; SHIFT occupies cycles 1..WIDTH; CHECK is cycle WIDTH+1; done=1 in cycle WIDTH+2; req_ready returns in cycle WIDTH+3.
- abort=1 during SHIFT or CHECK: on the next edge go to IDLE with sr_en=0.
  - No done pulse; result_data and mismatch are unchanged.
  - BSR contents are left partial.
- abort during DONE: ignored; done completes.
- New req_valid while busy: not accepted. The requester must hold req_valid; req_data is sampled only at acceptance.
- rst asserted mid-SHIFT: outputs go to reset values immediately (sr_en=0 asynchronously).
- Counter saturation: the counter never exceeds WIDTH-1. No wrap beyond WIDTH.

Decomposition:
- Shared package/include holds:
  - state localparams (S_IDLE=0, S_SHIFT=1, S_CHECK=2, S_DONE=3)
  - DIR_RIGHT=0, DIR_LEFT=1
- No sub-module inside the controller. The bit-select mux stays inline.
- The verification top instantiates bsr_load_ctrl plus the existing BSR (matching WIDTH) wired sr_* to d/dir/en and out to sr_out. The BSR reset is held inactive after the initial reset.

Test Plan:
- Reset: rst=1 mid-stream -> sr_en=0, done=0, req_ready=1, result_data=0 without waiting for a clock edge.
- Right load, WIDTH=4, req_data=4'b1011, req_dir=0 -> sr_d sequence 1,1,0,1 with sr_en=1 and sr_dir=0 for 4 cycles; done in cycle 6; result_data=4'b1011; mismatch=0.
- Left load, req_data=4'b1011, req_dir=1 -> sr_d sequence 1,0,1,1 with sr_dir=1; result_data=4'b1011; mismatch=0.
- Back-to-back: req_valid held high with 4'b0110 then 4'b1001 -> second accept in cycle WIDTH+3 after the first; no overlap of sr_en windows; both complete with mismatch=0.
- Abort: abort=1 at SHIFT k=2 -> sr_en=0 from the next cycle; no done; req_ready=1 one cycle later; previous result_data unchanged.
- Fault: force sr_out bit0 stuck at 0 and load 4'b1111 -> result_data=4'b1110 and mismatch=1 during done.

Source files
------------

// File: rtl/bsr_load_ctrl_pkg.sv
// Shared constants for the bidirectional shift register load sequencer:
// FSM state encoding and shift-direction codes.
package bsr_load_ctrl_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_SHIFT = 2'd1;
  localparam state_t S_CHECK = 2'd2;
  localparam state_t S_DONE  = 2'd3;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

endpackage

// File: rtl/bsr_load_ctrl.sv
// Streams a captured parallel word serially into a BSR over WIDTH cycles,
// then reads the BSR back and reports completion with a mismatch flag.
module bsr_load_ctrl
  import bsr_load_ctrl_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_data,
  input  logic             req_dir,
  input  logic             abort,
  output logic             sr_d,
  output logic             sr_dir,
  output logic             sr_en,
  input  logic [WIDTH-1:0] sr_out,
  output logic             done,
  output logic [WIDTH-1:0] result_data,
  output logic             mismatch
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] data_q;
  logic             dir_q;
  logic [WIDTH-1:0] result_q;
  logic             mismatch_q;

  logic             accept;
  logic             shifting;
  logic [CNT_W-1:0] bit_idx;
  logic             sel_bit;

  assign accept   = (state_q == S_IDLE) && req_valid;
  assign shifting = (state_q == S_SHIFT);

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (abort)                  state_d = S_IDLE;
        else if (cnt_q == LAST_CNT) state_d = S_CHECK;
      end
      S_CHECK: begin
        if (abort) state_d = S_IDLE;
        else       state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Counter stops at LAST_CNT; the SHIFT exit happens on that same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      data_q <= '0;
      dir_q  <= DIR_RIGHT;
    end else if (accept) begin
      cnt_q  <= '0;
      data_q <= req_data;
      dir_q  <= req_dir;
    end else if (shifting && !abort && (cnt_q != LAST_CNT)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Readback is taken only when CHECK completes; an abort leaves it untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q   <= '0;
      mismatch_q <= 1'b0;
    end else if ((state_q == S_CHECK) && !abort) begin
      result_q   <= sr_out;
      mismatch_q <= (sr_out != data_q);
    end
  end

  // Right shifts enter at the MSB, so LSB goes first; left shifts send MSB first.
  always_comb begin
    bit_idx = (dir_q == DIR_LEFT) ? (LAST_CNT - cnt_q) : cnt_q;
    sel_bit = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (bit_idx == CNT_W'(i)) sel_bit = data_q[i];
    end
  end

  assign sr_en       = shifting;
  assign sr_dir      = shifting & dir_q;
  assign sr_d        = shifting & sel_bit;
  assign req_ready   = (state_q == S_IDLE);
  assign done        = (state_q == S_DONE);
  assign result_data = result_q;
  assign mismatch    = mismatch_q;

endmodule

// File: tb/tb_bsr_load_ctrl.sv
// Self-checking bench for bsr_load_ctrl with a behavioural BSR and an
// optional stuck-at fault on its readback.
module tb_bsr_load_ctrl;

  localparam int WIDTH = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_data;
  logic             req_dir;
  logic             abort;
  logic             sr_d;
  logic             sr_dir;
  logic             sr_en;
  logic [WIDTH-1:0] sr_out;
  logic             done;
  logic [WIDTH-1:0] result_data;
  logic             mismatch;

  logic             bsr_rst;
  logic [WIDTH-1:0] bsr_q;
  logic [WIDTH-1:0] fault_mask;

  int checks = 0;
  int errors = 0;

  // Reference model state: last completed readback and its mismatch flag.
  logic [WIDTH-1:0] exp_result;
  logic             exp_mis;

  bsr_load_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_data    (req_data),
    .req_dir     (req_dir),
    .abort       (abort),
    .sr_d        (sr_d),
    .sr_dir      (sr_dir),
    .sr_en       (sr_en),
    .sr_out      (sr_out),
    .done        (done),
    .result_data (result_data),
    .mismatch    (mismatch)
  );

  always #5 clk = ~clk;

  // Behavioural BSR: dir=0 shifts right with d into the MSB, dir=1 left into the LSB.
  always_ff @(posedge clk or posedge bsr_rst) begin
    if (bsr_rst)    bsr_q <= '0;
    else if (sr_en) bsr_q <= sr_dir ? {bsr_q[WIDTH-2:0], sr_d} : {sr_d, bsr_q[WIDTH-1:1]};
  end

  assign sr_out = bsr_q & ~fault_mask;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (req_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic check_idle_after_abort();
    check("abort_sr_en",    32'(sr_en),       32'd0);
    check("abort_done",     32'(done),        32'd0);
    check("abort_ready",    32'(req_ready),   32'd1);
    check("abort_result",   32'(result_data), 32'(exp_result));
    check("abort_mismatch", 32'(mismatch),    32'(exp_mis));
    @(negedge clk);
    check("abort_no_done",  32'(done),        32'd0);
  endtask

  // One transaction, entered and left on a falling edge. abort_at: -1 none,
  // 0..WIDTH-1 abort in that shift cycle, WIDTH abort in the readback cycle.
  task automatic load(input logic [WIDTH-1:0] data, input logic dir,
                      input logic [WIDTH-1:0] mask, input bit hold,
                      input int abort_at, input bit abort_idle, input bit abort_done);
    bit   ok;
    logic exp_bit;
    wait_ready(ok);
    check("ready_wait", 32'(ok), 32'd1);
    if (!ok) return;
    req_valid  = 1'b1;
    req_data   = data;
    req_dir    = dir;
    fault_mask = mask;
    abort      = abort_idle;
    @(negedge clk);
    abort = 1'b0;
    if (hold) begin
      req_data = WIDTH'($urandom);
      req_dir  = 1'($urandom);
    end else begin
      req_valid = 1'b0;
    end
    for (int k = 0; k < WIDTH; k++) begin
      exp_bit = dir ? data[WIDTH-1-k] : data[k];
      check("shift_en",    32'(sr_en),     32'd1);
      check("shift_dir",   32'(sr_dir),    32'(dir));
      check("shift_d",     32'(sr_d),      32'(exp_bit));
      check("shift_ready", 32'(req_ready), 32'd0);
      check("shift_done",  32'(done),      32'd0);
      if (abort_at == k) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_idle_after_abort();
        return;
      end
      @(negedge clk);
    end
    check("check_en",    32'(sr_en),     32'd0);
    check("check_done",  32'(done),      32'd0);
    check("check_ready", 32'(req_ready), 32'd0);
    if (abort_at == WIDTH) begin
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check_idle_after_abort();
      return;
    end
    @(negedge clk);
    abort      = abort_done;
    exp_result = data & ~mask;
    exp_mis    = (exp_result != data);
    check("done_pulse",    32'(done),        32'd1);
    check("done_result",   32'(result_data), 32'(exp_result));
    check("done_mismatch", 32'(mismatch),    32'(exp_mis));
    check("done_ready",    32'(req_ready),   32'd0);
    check("done_en",       32'(sr_en),       32'd0);
    @(negedge clk);
    abort = 1'b0;
    check("after_ready", 32'(req_ready), 32'd1);
    check("after_done",  32'(done),      32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst        = 1'b1;
    bsr_rst    = 1'b1;
    req_valid  = 1'b0;
    req_data   = '0;
    req_dir    = 1'b0;
    abort      = 1'b0;
    fault_mask = '0;
    exp_result = '0;
    exp_mis    = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready",    32'(req_ready),   32'd1);
    check("rst_en",       32'(sr_en),       32'd0);
    check("rst_d",        32'(sr_d),        32'd0);
    check("rst_done",     32'(done),        32'd0);
    check("rst_result",   32'(result_data), 32'd0);
    check("rst_mismatch", 32'(mismatch),    32'd0);
    rst     = 1'b0;
    bsr_rst = 1'b0;
    @(negedge clk);

    load(4'b1011, 1'b0, 4'b0000, 1'b0, -1, 1'b0, 1'b0);
    load(4'b1011, 1'b1, 4'b0000, 1'b0, -1, 1'b0, 1'b0);
    load(4'b0110, 1'b0, 4'b0000, 1'b1, -1, 1'b0, 1'b0);
    load(4'b1001, 1'b1, 4'b0000, 1'b0, -1, 1'b0, 1'b0);
    load(4'b0101, 1'b0, 4'b0000, 1'b0, 2, 1'b0, 1'b0);
    load(4'b1111, 1'b0, 4'b0001, 1'b0, -1, 1'b0, 1'b0);
    load(4'b0011, 1'b1, 4'b0000, 1'b0, WIDTH, 1'b0, 1'b0);
    load(4'b1100, 1'b1, 4'b0000, 1'b0, -1, 1'b1, 1'b1);

    for (int n = 0; n < 24; n++) begin
      logic [WIDTH-1:0] d;
      logic [WIDTH-1:0] m;
      int               ab;
      d  = WIDTH'($urandom);
      m  = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom) : '0;
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, WIDTH)) : -1;
      load(d, 1'($urandom), m, 1'b0, ab, 1'($urandom), 1'($urandom));
    end

    // Asynchronous reset in the middle of a shift, checked before any clock edge.
    load(4'b1101, 1'b0, 4'b0000, 1'b0, -1, 1'b0, 1'b0);
    req_valid = 1'b1;
    req_data  = 4'b1010;
    req_dir   = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_en",       32'(sr_en),       32'd0);
    check("midrst_d",        32'(sr_d),        32'd0);
    check("midrst_dir",      32'(sr_dir),      32'd0);
    check("midrst_done",     32'(done),        32'd0);
    check("midrst_ready",    32'(req_ready),   32'd1);
    check("midrst_result",   32'(result_data), 32'd0);
    check("midrst_mismatch", 32'(mismatch),    32'd0);
    @(negedge clk);
    rst        = 1'b0;
    exp_result = '0;
    exp_mis    = 1'b0;
    @(negedge clk);
    load(4'b0111, 1'b1, 4'b0000, 1'b0, -1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
